// File: rtl/st7735_window_scheduler.sv
// ST7735 window writer: request -> CASET/RASET/RAMWR command frame followed by RGB565 pixel bytes.
// Optional feature macro ST7735_SCHED_FILL_EN adds REQ_FILL/REQ_COLOR for solid-colour fills.
module st7735_window_scheduler #(
    parameter int WIDTH      = 128,
    parameter int HEIGHT     = 160,
    parameter int COL_OFFSET = 2,
    parameter int ROW_OFFSET = 1
) (
    input  logic        SYSTEM_CLK,
    input  logic        RST_N,
    input  logic        INIT_DONE,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [7:0]  REQ_X0,
    input  logic [7:0]  REQ_X1,
    input  logic [7:0]  REQ_Y0,
    input  logic [7:0]  REQ_Y1,
`ifdef ST7735_SCHED_FILL_EN
    input  logic        REQ_FILL,
    input  logic [15:0] REQ_COLOR,
`endif
    input  logic        PIX_VALID,
    output logic        PIX_READY,
    input  logic [15:0] PIX_DATA,
    output logic        TX_VALID,
    input  logic        TX_READY,
    output logic [7:0]  TX_BYTE,
    output logic        TX_DC,
    output logic        TX_LAST,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);

    typedef enum logic [3:0] {
        IDLE, CASET_C, CASET_D, RASET_C, RASET_D, RAMWR_C,
        PIX_WAIT, PIX_HI, PIX_LO, FINISH
    } state_t;

    localparam logic [8:0]  WIDTH_L   = 9'(WIDTH);
    localparam logic [8:0]  HEIGHT_L  = 9'(HEIGHT);
    localparam logic [15:0] COL_OFF_L = 16'(COL_OFFSET);
    localparam logic [15:0] ROW_OFF_L = 16'(ROW_OFFSET);

    state_t      state_reg;
    logic [7:0]  x0_reg, x1_reg, y0_reg, y1_reg;
    logic [1:0]  byte_idx_reg;
    logic [14:0] pix_count_reg;
    logic [15:0] pix_data_reg;
    logic        fill_reg;
    logic        tx_valid_reg;
    logic [7:0]  tx_byte_reg;
    logic        tx_dc_reg;
    logic        tx_last_reg;
    logic        pix_ready_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        err_reg;

    logic        fill_req;
    logic [15:0] fill_color;
`ifdef ST7735_SCHED_FILL_EN
    assign fill_req   = REQ_FILL;
    assign fill_color = REQ_COLOR;
`else
    assign fill_req   = 1'b0;
    assign fill_color = 16'h0000;
`endif

    logic        req_fire;
    logic        req_ok;
    logic        tx_fire;
    logic [8:0]  win_w, win_h;
    logic [14:0] win_area;

    assign req_fire = REQ_VALID && INIT_DONE && (state_reg == IDLE);
    assign req_ok   = (REQ_X0 <= REQ_X1) && ({1'b0, REQ_X1} < WIDTH_L) &&
                      (REQ_Y0 <= REQ_Y1) && ({1'b0, REQ_Y1} < HEIGHT_L);
    assign tx_fire  = tx_valid_reg && TX_READY;
    assign win_w    = {1'b0, REQ_X1} - {1'b0, REQ_X0} + 9'd1;
    assign win_h    = {1'b0, REQ_Y1} - {1'b0, REQ_Y0} + 9'd1;
    // Only meaningful for valid windows; 128x160 = 20480 fits in 15 bits.
    assign win_area = 15'(win_w) * 15'(win_h);

    // Address payload: [0..3] = CASET bytes, [4..7] = RASET bytes, MSB first.
    logic [15:0] win_words [4];
    logic [7:0]  win_bytes [8];
    logic [1:0]  byte_idx_inc;

    assign win_words[0] = {8'd0, x0_reg} + COL_OFF_L;
    assign win_words[1] = {8'd0, x1_reg} + COL_OFF_L;
    assign win_words[2] = {8'd0, y0_reg} + ROW_OFF_L;
    assign win_words[3] = {8'd0, y1_reg} + ROW_OFF_L;

    for (genvar gi = 0; gi < 4; gi++) begin : g_split
        assign win_bytes[2*gi]   = win_words[gi][15:8];
        assign win_bytes[2*gi+1] = win_words[gi][7:0];
    end

    assign byte_idx_inc = byte_idx_reg + 2'd1;

    always_ff @(posedge SYSTEM_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg     <= IDLE;
            x0_reg        <= 8'd0;
            x1_reg        <= 8'd0;
            y0_reg        <= 8'd0;
            y1_reg        <= 8'd0;
            byte_idx_reg  <= 2'd0;
            pix_count_reg <= 15'd0;
            pix_data_reg  <= 16'd0;
            fill_reg      <= 1'b0;
            tx_valid_reg  <= 1'b0;
            tx_byte_reg   <= 8'd0;
            tx_dc_reg     <= 1'b0;
            tx_last_reg   <= 1'b0;
            pix_ready_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_fire) begin
                        if (req_ok) begin
                            x0_reg        <= REQ_X0;
                            x1_reg        <= REQ_X1;
                            y0_reg        <= REQ_Y0;
                            y1_reg        <= REQ_Y1;
                            pix_count_reg <= win_area;
                            fill_reg      <= fill_req;
                            pix_data_reg  <= fill_color;
                            busy_reg      <= 1'b1;
                            tx_valid_reg  <= 1'b1;
                            tx_byte_reg   <= 8'h2A;
                            tx_dc_reg     <= 1'b0;
                            tx_last_reg   <= 1'b0;
                            state_reg     <= CASET_C;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                CASET_C: begin
                    if (tx_fire) begin
                        byte_idx_reg <= 2'd0;
                        tx_byte_reg  <= win_bytes[0];
                        tx_dc_reg    <= 1'b1;
                        state_reg    <= CASET_D;
                    end
                end
                CASET_D: begin
                    if (tx_fire) begin
                        byte_idx_reg <= byte_idx_inc;
                        if (byte_idx_reg == 2'd3) begin
                            tx_byte_reg <= 8'h2B;
                            tx_dc_reg   <= 1'b0;
                            tx_last_reg <= 1'b0;
                            state_reg   <= RASET_C;
                        end else begin
                            tx_byte_reg <= win_bytes[{1'b0, byte_idx_inc}];
                            tx_last_reg <= (byte_idx_inc == 2'd3);
                        end
                    end
                end
                RASET_C: begin
                    if (tx_fire) begin
                        byte_idx_reg <= 2'd0;
                        tx_byte_reg  <= win_bytes[4];
                        tx_dc_reg    <= 1'b1;
                        state_reg    <= RASET_D;
                    end
                end
                RASET_D: begin
                    if (tx_fire) begin
                        byte_idx_reg <= byte_idx_inc;
                        if (byte_idx_reg == 2'd3) begin
                            tx_byte_reg <= 8'h2C;
                            tx_dc_reg   <= 1'b0;
                            tx_last_reg <= 1'b0;
                            state_reg   <= RAMWR_C;
                        end else begin
                            tx_byte_reg <= win_bytes[{1'b1, byte_idx_inc}];
                            tx_last_reg <= (byte_idx_inc == 2'd3);
                        end
                    end
                end
                RAMWR_C: begin
                    // RAMWR keeps CS asserted: the pixel bytes belong to the same frame.
                    if (tx_fire) begin
                        if (fill_reg) begin
                            tx_byte_reg <= pix_data_reg[15:8];
                            tx_dc_reg   <= 1'b1;
                            state_reg   <= PIX_HI;
                        end else begin
                            tx_valid_reg  <= 1'b0;
                            pix_ready_reg <= 1'b1;
                            state_reg     <= PIX_WAIT;
                        end
                    end
                end
                PIX_WAIT: begin
                    if (PIX_VALID && pix_ready_reg) begin
                        pix_data_reg  <= PIX_DATA;
                        pix_ready_reg <= 1'b0;
                        tx_valid_reg  <= 1'b1;
                        tx_byte_reg   <= PIX_DATA[15:8];
                        tx_dc_reg     <= 1'b1;
                        tx_last_reg   <= 1'b0;
                        state_reg     <= PIX_HI;
                    end
                end
                PIX_HI: begin
                    if (tx_fire) begin
                        tx_byte_reg <= pix_data_reg[7:0];
                        tx_last_reg <= (pix_count_reg == 15'd1);
                        state_reg   <= PIX_LO;
                    end
                end
                PIX_LO: begin
                    if (tx_fire) begin
                        tx_last_reg <= 1'b0;
                        if (pix_count_reg == 15'd1) begin
                            pix_count_reg <= 15'd0;
                            tx_valid_reg  <= 1'b0;
                            done_reg      <= 1'b1;
                            state_reg     <= FINISH;
                        end else begin
                            pix_count_reg <= pix_count_reg - 15'd1;
                            if (fill_reg) begin
                                tx_byte_reg <= pix_data_reg[15:8];
                                state_reg   <= PIX_HI;
                            end else begin
                                tx_valid_reg  <= 1'b0;
                                pix_ready_reg <= 1'b1;
                                state_reg     <= PIX_WAIT;
                            end
                        end
                    end
                end
                FINISH: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Gated by RST_N so the handshake is closed while reset is held.
    assign REQ_READY = RST_N && INIT_DONE && (state_reg == IDLE);
    assign PIX_READY = pix_ready_reg;
    assign TX_VALID  = tx_valid_reg;
    assign TX_BYTE   = tx_byte_reg;
    assign TX_DC     = tx_dc_reg;
    assign TX_LAST   = tx_last_reg;
    assign BUSY      = busy_reg;
    assign DONE      = done_reg;
    assign ERR       = err_reg;

endmodule

// File: tb/tb_st7735_window_scheduler.sv
// Scoreboard bench for st7735_window_scheduler: a byte-list model of each window is queued at
// stimulus time and a negedge monitor pops and compares on every TX handshake.
module tb_st7735_window_scheduler;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, init_done, req_valid, req_ready;
    logic [7:0]  req_x0, req_x1, req_y0, req_y1;
    logic        pix_valid, pix_ready;
    logic [15:0] pix_data;
    logic        tx_valid, tx_ready;
    logic [7:0]  tx_byte;
    logic        tx_dc, tx_last, busy, done, err;
`ifdef ST7735_SCHED_FILL_EN
    logic        req_fill;
    logic [15:0] req_color;
`endif

    st7735_window_scheduler dut (
        .SYSTEM_CLK (clk),
        .RST_N      (rst_n),
        .INIT_DONE  (init_done),
        .REQ_VALID  (req_valid),
        .REQ_READY  (req_ready),
        .REQ_X0     (req_x0),
        .REQ_X1     (req_x1),
        .REQ_Y0     (req_y0),
        .REQ_Y1     (req_y1),
`ifdef ST7735_SCHED_FILL_EN
        .REQ_FILL   (req_fill),
        .REQ_COLOR  (req_color),
`endif
        .PIX_VALID  (pix_valid),
        .PIX_READY  (pix_ready),
        .PIX_DATA   (pix_data),
        .TX_VALID   (tx_valid),
        .TX_READY   (tx_ready),
        .TX_BYTE    (tx_byte),
        .TX_DC      (tx_dc),
        .TX_LAST    (tx_last),
        .BUSY       (busy),
        .DONE       (done),
        .ERR        (err)
    );

    typedef struct packed {
        logic [7:0] b;
        logic       dc;
        logic       last;
        logic       fin;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] pix_q[$];

    int checks = 0;
    int errors = 0;
    int tx_hs_count = 0;
    int pix_hs_count = 0;
    int err_count = 0;
    int done_count = 0;

    bit tx_rand = 0;
    bit pv_rand = 0;
    bit no_pixready = 0;
    bit req_model_valid = 0;

    // monitor state
    bit          m_stall_prev = 0;
    logic [10:0] m_hold = '0;
    bit          m_start_chk = 0;
    bit          m_start_valid = 0;
    bit          m_done_exp = 0;
    bit          m_after_done = 0;
    bit          m_err_prev = 0;
    exp_t        m_e;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h @%0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit win_valid(input int x0, input int y0, input int x1, input int y1);
        return (x0 <= x1) && (x1 < 128) && (y0 <= y1) && (y1 < 160);
    endfunction

    task automatic push_b(input logic [7:0] b, input bit dc, input bit last, input bit fin);
        exp_t e;
        e.b = b; e.dc = dc; e.last = last; e.fin = fin;
        exp_q.push_back(e);
    endtask

    task automatic push_addr(input logic [7:0] cmd, input int a, input int b);
        logic [15:0] sa, sb;
        sa = 16'(a);
        sb = 16'(b);
        push_b(cmd, 1'b0, 1'b0, 1'b0);
        push_b(sa[15:8], 1'b1, 1'b0, 1'b0);
        push_b(sa[7:0],  1'b1, 1'b0, 1'b0);
        push_b(sb[15:8], 1'b1, 1'b0, 1'b0);
        push_b(sb[7:0],  1'b1, 1'b1, 1'b0);
    endtask

    task automatic prep_window(input int x0, input int y0, input int x1, input int y1,
                               input bit use_fixed, input logic [15:0] fixed, input bit stream,
                               output int npix);
        logic [15:0] p;
        push_addr(8'h2A, x0 + 2, x1 + 2);
        push_addr(8'h2B, y0 + 1, y1 + 1);
        push_b(8'h2C, 1'b0, 1'b0, 1'b0);
        npix = (x1 - x0 + 1) * (y1 - y0 + 1);
        for (int i = 0; i < npix; i++) begin
            p = use_fixed ? fixed : 16'($urandom);
            if (stream) pix_q.push_back(p);
            push_b(p[15:8], 1'b1, 1'b0, 1'b0);
            push_b(p[7:0],  1'b1, (i == npix - 1), (i == npix - 1));
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic issue_req(input int x0, input int y0, input int x1, input int y1);
        bit acc;
        acc = 0;
        @(posedge clk); #1;
        req_x0 = 8'(x0); req_y0 = 8'(y0); req_x1 = 8'(x1); req_y1 = 8'(y1);
        req_model_valid = win_valid(x0, y0, x1, y1);
        req_valid = 1'b1;
        for (int c = 0; c < 200 && !acc; c++) begin
            @(negedge clk);
            if (req_ready) acc = 1;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        if (!acc) chk(1'b0, "req_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input int exp_pix, input int pix_base, input int bound);
        bit seen;
        int d0;
        seen = 0;
        d0 = done_count;
        for (int c = 0; c < bound && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk(seen, "done_timeout", 32'(seen), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk(exp_q.size() == 0, "bytes_left", 32'(exp_q.size()), 32'd0);
        chk(pix_hs_count - pix_base == exp_pix, "pix_handshakes", 32'(pix_hs_count - pix_base), 32'(exp_pix));
        chk(done_count - d0 == 1, "done_once", 32'(done_count - d0), 32'd1);
    endtask

    // ---------------- input drivers (TX_READY, pixel stream) ----------------
    initial begin
        forever begin
            @(posedge clk); #1;
            tx_ready = tx_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pix_q.size() > 0 && (!pv_rand || $urandom_range(0, 3) != 0)) begin
                pix_valid = 1'b1;
                pix_data  = pix_q[0];
            end else begin
                pix_valid = 1'b0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_stall_prev = 0; m_start_chk = 0; m_done_exp = 0;
                m_after_done = 0; m_err_prev = 0;
            end else begin
                if (m_start_chk) begin
                    if (m_start_valid)
                        chk(tx_valid && tx_byte == 8'h2A && !tx_dc && busy && !err, "start_2A",
                            32'({tx_valid, tx_byte, tx_dc, busy, err}), 32'({1'b1, 8'h2A, 1'b0, 1'b1, 1'b0}));
                    else
                        chk(err && !busy && !tx_valid, "err_pulse",
                            32'({err, busy, tx_valid}), 32'({1'b1, 1'b0, 1'b0}));
                end
                m_start_chk   = req_valid && req_ready;
                m_start_valid = req_model_valid;

                if (m_stall_prev)
                    chk({tx_valid, tx_byte, tx_dc, tx_last} == m_hold, "stall_hold",
                        32'({tx_valid, tx_byte, tx_dc, tx_last}), 32'(m_hold));
                m_stall_prev = tx_valid && !tx_ready;
                m_hold = {tx_valid, tx_byte, tx_dc, tx_last};

                if (m_done_exp) begin
                    chk(done && busy, "done_pulse", 32'({done, busy}), 32'd3);
                    m_done_exp = 0;
                    m_after_done = 1;
                end else if (m_after_done) begin
                    chk(!done && !busy && req_ready == init_done, "post_done",
                        32'({done, busy, req_ready}), 32'({1'b0, 1'b0, init_done}));
                    m_after_done = 0;
                end else if (done) begin
                    chk(1'b0, "spurious_done", 32'd1, 32'd0);
                end
                if (done) done_count++;

                if (m_err_prev) chk(!err, "err_one_pulse", 32'(err), 32'd0);
                m_err_prev = err;
                if (err) err_count++;

                if (no_pixready) chk(!pix_ready, "fill_pix_ready", 32'(pix_ready), 32'd0);

                if (tx_valid && tx_ready) begin
                    tx_hs_count++;
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_byte", 32'(tx_byte), 32'd0);
                    end else begin
                        m_e = exp_q.pop_front();
                        chk(tx_byte == m_e.b && tx_dc == m_e.dc && tx_last == m_e.last, "tx_byte",
                            32'({tx_byte, tx_dc, tx_last}), 32'({m_e.b, m_e.dc, m_e.last}));
                        if (m_e.fin) m_done_exp = 1;
                    end
                end

                if (pix_valid && pix_ready) begin
                    pix_hs_count++;
                    if (pix_q.size() > 0) void'(pix_q.pop_front());
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #3000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int np, pb, e0, t0;
        int rx0, rx1, ry0, ry1;
        rst_n = 1'b0; init_done = 1'b1; req_valid = 1'b0;
        req_x0 = 8'd0; req_x1 = 8'd0; req_y0 = 8'd0; req_y1 = 8'd0;
        tx_ready = 1'b0; pix_valid = 1'b0; pix_data = 16'd0;
`ifdef ST7735_SCHED_FILL_EN
        req_fill = 1'b0; req_color = 16'd0;
`endif
        repeat (2) @(negedge clk);
        chk(!tx_valid, "rst_tx_valid", 32'(tx_valid), 32'd0);
        chk(!busy, "rst_busy", 32'(busy), 32'd0);
        chk(!pix_ready, "rst_pix_ready", 32'(pix_ready), 32'd0);
        chk(!req_ready, "rst_req_ready", 32'(req_ready), 32'd0);
        chk(tx_byte == 8'd0, "rst_tx_byte", 32'(tx_byte), 32'd0);
        chk({done, err, tx_dc, tx_last} == 4'd0, "rst_flags", 32'({done, err, tx_dc, tx_last}), 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        chk(req_ready, "idle_ready", 32'(req_ready), 32'd1);

        // single red pixel, TX_READY high
        pb = pix_hs_count;
        prep_window(0, 0, 0, 0, 1'b1, 16'hF800, 1'b1, np);
        issue_req(0, 0, 0, 0);
        wait_done(np, pb, 400);

        // 2x2 window with back-pressure and a bursty pixel source
        tx_rand = 1; pv_rand = 1;
        pb = pix_hs_count;
        prep_window(10, 20, 11, 21, 1'b0, 16'h0, 1'b1, np);
        issue_req(10, 20, 11, 21);
        wait_done(np, pb, 2000);

        // invalid windows: x0>x1, x1 off-panel, y1 off-panel
        for (int k = 0; k < 3; k++) begin
            e0 = err_count; t0 = tx_hs_count;
            case (k)
                0:       issue_req(5, 0, 4, 0);
                1:       issue_req(0, 0, 128, 0);
                default: issue_req(0, 0, 0, 160);
            endcase
            repeat (4) @(posedge clk);
            #1;
            chk(err_count - e0 == 1, "err_count", 32'(err_count - e0), 32'd1);
            chk(tx_hs_count == t0, "err_no_tx", 32'(tx_hs_count - t0), 32'd0);
            chk(!busy, "err_busy", 32'(busy), 32'd0);
        end

        // INIT_DONE low blocks acceptance
        tx_rand = 0; pv_rand = 0;
        pb = pix_hs_count;
        prep_window(1, 2, 2, 3, 1'b0, 16'h0, 1'b1, np);
        @(posedge clk); #1;
        init_done = 1'b0;
        req_x0 = 8'd1; req_y0 = 8'd2; req_x1 = 8'd2; req_y1 = 8'd3;
        req_model_valid = 1'b1;
        req_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk(!req_ready, "ready_no_init", 32'(req_ready), 32'd0);
            chk(!tx_valid && !busy, "idle_no_init", 32'({tx_valid, busy}), 32'd0);
        end
        @(posedge clk); #1;
        init_done = 1'b1;
        @(negedge clk);
        chk(req_ready, "ready_after_init", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_done(np, pb, 400);

        // small random windows under random back-pressure
        tx_rand = 1; pv_rand = 1;
        for (int k = 0; k < 3; k++) begin
            rx0 = $urandom_range(0, 127);
            rx1 = $urandom_range(rx0, (rx0 + 3 > 127) ? 127 : rx0 + 3);
            ry0 = $urandom_range(0, 159);
            ry1 = $urandom_range(ry0, (ry0 + 2 > 159) ? 159 : ry0 + 2);
            pb = pix_hs_count;
            prep_window(rx0, ry0, rx1, ry1, 1'b0, 16'h0, 1'b1, np);
            issue_req(rx0, ry0, rx1, ry1);
            wait_done(np, pb, np * 40 + 300);
        end

        // reset in PIX_HI abandons the frame; next request restarts at 0x2A
        tx_rand = 0; pv_rand = 0;
        prep_window(3, 3, 4, 4, 1'b0, 16'h0, 1'b1, np);
        issue_req(3, 3, 4, 4);
        begin
            bit got;
            got = 0;
            for (int c = 0; c < 200 && !got; c++) begin
                @(negedge clk);
                if (pix_valid && pix_ready) got = 1;
            end
            chk(got, "pix_hs_timeout", 32'(got), 32'd1);
        end
        @(posedge clk); #1;
        chk(tx_valid && tx_dc, "pix_hi_active", 32'({tx_valid, tx_dc}), 32'd3);
        rst_n = 1'b0;
        #1;
        chk(!tx_valid, "rst_mid_tx_valid", 32'(tx_valid), 32'd0);
        chk({busy, pix_ready, req_ready, tx_last, tx_dc} == 5'd0, "rst_mid_flags",
            32'({busy, pix_ready, req_ready, tx_last, tx_dc}), 32'd0);
        chk(tx_byte == 8'd0, "rst_mid_tx_byte", 32'(tx_byte), 32'd0);
        exp_q.delete();
        pix_q.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        pb = pix_hs_count;
        prep_window(0, 0, 1, 0, 1'b0, 16'h0, 1'b1, np);
        issue_req(0, 0, 1, 0);
        wait_done(np, pb, 400);

`ifdef ST7735_SCHED_FILL_EN
        // solid fill: no pixel handshakes, PIX_READY stays low
        req_fill = 1'b1; req_color = 16'h07E0;
        no_pixready = 1;
        pb = pix_hs_count;
        prep_window(0, 0, 1, 1, 1'b1, 16'h07E0, 1'b0, np);
        issue_req(0, 0, 1, 1);
        wait_done(0, pb, 400);
        no_pixready = 0;
        req_fill = 1'b0;
`endif

        // full screen, TX_READY high, continuous pixel source
        pb = pix_hs_count;
        prep_window(0, 0, 127, 159, 1'b0, 16'h0, 1'b1, np);
        chk(np == 20480, "full_npix_model", 32'(np), 32'd20480);
        issue_req(0, 0, 127, 159);
        wait_done(np, pb, np * 4 + 200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
